// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM types: data word and RAM status encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - memory arbiter FSM states, grant kinds and round-robin helper.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        IREAD = 2'b00,
        DREAD = 2'b01,
        WRITE = 2'b10
    } grant_kind_t;

    function automatic int next_index(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first requester at or after ptr.
module rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);

    int j;

    // Scan farthest-first so the requester closest to ptr is the last (winning) write.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[W'(j)]) begin
                idx   = W'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter of CPU I/D ports onto one RAM port.
// Optional per-CPU completion counters (grant_count) under MEM_ARB_PERF_EN.
module memory_arbiter
    import cpu_types_pkg::*;
    import mem_arb_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = $bits(word_t)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [CPUS-1:0]               iREN,
    input  logic [CPUS-1:0]               dREN,
    input  logic [CPUS-1:0]               dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]   iaddr,
    input  logic [CPUS-1:0][ADDR_W-1:0]   daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]               iwait,
    output logic [CPUS-1:0]               dwait,
    output logic [CPUS-1:0][WORD_W-1:0]   iload,
    output logic [CPUS-1:0][WORD_W-1:0]   dload,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [ADDR_W-1:0]             ramaddr,
    output logic [WORD_W-1:0]             ramstore,
    input  logic [WORD_W-1:0]             ramload,
    input  logic [1:0]                    ramstate
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CPUS-1:0][31:0]         grant_count
`endif
);

    localparam int RR_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t  state, state_next;
    grant_kind_t kind, kind_next;
    logic [RR_W-1:0] rr, rr_next, owner, owner_next, owner_inc, pick_idx;
    logic            pick_valid, held, done;
    logic [CPUS-1:0] any_req;
    ramstate_t       rs;

    assign rs        = ramstate_t'(ramstate);
    assign any_req   = iREN | dREN | dWEN;
    assign owner_inc = RR_W'(next_index(int'(owner), CPUS));

    rr_picker #(.N(CPUS), .W(RR_W)) u_picker (
        .req   (any_req),
        .ptr   (rr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            rr    <= '0;
            owner <= '0;
            kind  <= IREAD;
        end else begin
            state <= state_next;
            rr    <= rr_next;
            owner <= owner_next;
            kind  <= kind_next;
        end
    end

    always_comb begin
        state_next = state;
        rr_next    = rr;
        owner_next = owner;
        kind_next  = kind;
        held       = 1'b0;
        done       = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = XFER;
                    owner_next = pick_idx;
                    if (dWEN[pick_idx])      kind_next = WRITE;
                    else if (dREN[pick_idx]) kind_next = DREAD;
                    else                     kind_next = IREAD;
                end
            end
            XFER: begin
                case (kind)
                    WRITE:   held = dWEN[owner];
                    DREAD:   held = dREN[owner];
                    default: held = iREN[owner];
                endcase
                // A dropped request aborts without touching the RAM.
                if (!held) begin
                    state_next = IDLE;
                    rr_next    = owner_inc;
                end else begin
                    ramREN   = (kind != WRITE);
                    ramWEN   = (kind == WRITE);
                    ramaddr  = (kind == IREAD) ? iaddr[owner] : daddr[owner];
                    ramstore = (kind == WRITE) ? dstore[owner] : '0;
                    if (rs == ACCESS) begin
                        done       = 1'b1;
                        state_next = IDLE;
                        rr_next    = owner_inc;
                    end else if (rs == ERROR) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // dwait covers both data requests; only the completed kind is released.
    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            iwait[c] = iREN[c] & ~(done & (owner == RR_W'(c)) & (kind == IREAD));
            dwait[c] = (dREN[c] & ~(done & (owner == RR_W'(c)) & (kind == DREAD)))
                     | (dWEN[c] & ~(done & (owner == RR_W'(c)) & (kind == WRITE)));
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_count <= '0;
        end else if (done && (grant_count[owner] != 32'hFFFF_FFFF)) begin
            grant_count[owner] <= grant_count[owner] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter (table, corner sequences, random vs model).
module tb_memory_arbiter;

    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int WW   = 32;
    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [CPUS-1:0]         iREN, dREN, dWEN, iwait, dwait;
    logic [CPUS-1:0][AW-1:0] iaddr, daddr;
    logic [CPUS-1:0][WW-1:0] dstore, iload, dload;
    logic                    ramREN, ramWEN;
    logic [AW-1:0]           ramaddr;
    logic [WW-1:0]           ramstore, ramload;
    logic [1:0]              ramstate;
`ifdef MEM_ARB_PERF_EN
    logic [CPUS-1:0][31:0]   grant_count;
`endif

    memory_arbiter #(.CPUS(CPUS), .ADDR_W(AW), .WORD_W(WW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .iaddr    (iaddr),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_ARB_PERF_EN
        ,
        .grant_count (grant_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0]  ir, dr, dw, rs;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dwt;
    } vec_t;

    vec_t tbl [19];

    // Reference model: a grant is (owner, kind 0=I 1=D 2=W); ptr is the round-robin start.
    bit          m_busy;
    int          m_own, m_kind, m_ptr;
    int unsigned m_cnt [CPUS];

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_kind = 0; m_ptr = 0;
        for (int c = 0; c < CPUS; c++) m_cnt[c] = 0;
    endtask

    task automatic model_step();
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic [1:0]  e_iw, e_dw;
        bit          held, dn, own;
        int          c;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; held = 0; dn = 0;
        if (m_busy) begin
            held = (m_kind == 2) ? dWEN[m_own] : (m_kind == 1) ? dREN[m_own] : iREN[m_own];
            if (held) begin
                if (m_kind == 2) begin
                    e_wen = 1; e_addr = daddr[m_own]; e_store = dstore[m_own];
                end else begin
                    e_ren = 1; e_addr = (m_kind == 1) ? daddr[m_own] : iaddr[m_own];
                end
                dn = (ramstate == S_ACC);
            end
        end
        for (int k = 0; k < CPUS; k++) begin
            own     = dn && (m_own == k);
            e_iw[k] = iREN[k] && !(own && m_kind == 0);
            e_dw[k] = (dREN[k] && !(own && m_kind == 1)) || (dWEN[k] && !(own && m_kind == 2));
        end
        check("rnd_ram", {ramREN, ramWEN, ramaddr, ramstore}, {e_ren, e_wen, e_addr, e_store});
        check("rnd_waits", {iwait, dwait}, {e_iw, e_dw});
        check("rnd_load", {iload, dload}, {ramload, ramload, ramload, ramload});
        if (!m_busy) begin
            for (int i = 0; i < CPUS; i++) begin
                c = (m_ptr + i) % CPUS;
                if (!m_busy && (iREN[c] || dREN[c] || dWEN[c])) begin
                    m_busy = 1; m_own = c;
                    m_kind = dWEN[c] ? 2 : dREN[c] ? 1 : 0;
                end
            end
        end else if (!held || dn) begin
            if (dn) m_cnt[m_own]++;
            m_busy = 0;
            m_ptr  = (m_own + 1) % CPUS;
        end else if (ramstate == S_ERR) begin
            m_busy = 0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        iREN = 2'b01; dREN = 2'b10; dWEN = 2'b00;
        ramstate = S_FREE;
        #2;
        check("rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 66'd0);
        check("rst_waits", {iwait, dwait}, 4'b0110);
        @(posedge CLK); #1;
        RST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0;
    endtask

    initial begin
        tbl[0]  = '{2'b01, 2'b00, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b01, 2'b00};
        tbl[1]  = '{2'b01, 2'b00, 2'b00, S_BUSY, 1, 0, 32'h40, 32'h0, 2'b01, 2'b00};
        tbl[2]  = '{2'b01, 2'b00, 2'b00, S_ACC,  1, 0, 32'h40, 32'h0, 2'b00, 2'b00};
        tbl[3]  = '{2'b00, 2'b00, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b00, 2'b00};
        tbl[4]  = '{2'b01, 2'b01, 2'b01, S_FREE, 0, 0, 32'h00, 32'h0, 2'b01, 2'b01};
        tbl[5]  = '{2'b01, 2'b01, 2'b01, S_ACC,  0, 1, 32'h80, 32'h5, 2'b01, 2'b01};
        tbl[6]  = '{2'b01, 2'b01, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b01, 2'b01};
        tbl[7]  = '{2'b01, 2'b01, 2'b00, S_ACC,  1, 0, 32'h80, 32'h0, 2'b01, 2'b00};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b00, 2'b00};
        tbl[9]  = '{2'b00, 2'b11, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b00, 2'b11};
        tbl[10] = '{2'b00, 2'b11, 2'b00, S_ERR,  1, 0, 32'h84, 32'h0, 2'b00, 2'b11};
        tbl[11] = '{2'b00, 2'b11, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b00, 2'b11};
        tbl[12] = '{2'b00, 2'b11, 2'b00, S_ACC,  1, 0, 32'h84, 32'h0, 2'b00, 2'b01};
        tbl[13] = '{2'b00, 2'b11, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b00, 2'b11};
        tbl[14] = '{2'b00, 2'b11, 2'b00, S_ACC,  1, 0, 32'h80, 32'h0, 2'b00, 2'b10};
        tbl[15] = '{2'b10, 2'b00, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b10, 2'b00};
        tbl[16] = '{2'b00, 2'b00, 2'b00, S_ACC,  0, 0, 32'h00, 32'h0, 2'b00, 2'b00};
        tbl[17] = '{2'b11, 2'b00, 2'b00, S_FREE, 0, 0, 32'h00, 32'h0, 2'b11, 2'b00};
        tbl[18] = '{2'b11, 2'b00, 2'b00, S_ACC,  1, 0, 32'h40, 32'h0, 2'b10, 2'b00};

        iaddr[0] = 32'h40; iaddr[1] = 32'h44;
        daddr[0] = 32'h80; daddr[1] = 32'h84;
        dstore[0] = 32'h5; dstore[1] = 32'h7;
        ramload = 32'hDEADBEEF;

        // Directed table from reset.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            iREN = tbl[i].ir; dREN = tbl[i].dr; dWEN = tbl[i].dw; ramstate = tbl[i].rs;
            #4;
            check($sformatf("tbl%0d_ram", i), {ramREN, ramWEN, ramaddr, ramstore},
                  {tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].store});
            check($sformatf("tbl%0d_waits", i), {iwait, dwait}, {tbl[i].iw, tbl[i].dwt});
            check($sformatf("tbl%0d_load", i), {iload[0], dload[1]}, {32'hDEADBEEF, 32'hDEADBEEF});
            @(posedge CLK); #1;
        end

        // Both CPUs streaming data reads alternate 0,1,0,1 from reset.
        do_reset();
        dREN = 2'b11; ramstate = S_ACC;
        for (int k = 0; k < 8; k++) begin
            #4;
            if (k % 2 == 1)
                check($sformatf("alt%0d_addr", k), {ramREN, ramaddr},
                      {1'b1, ((k % 4) == 1) ? 32'h80 : 32'h84});
            @(posedge CLK); #1;
        end

        // Reset mid-transfer: strobe drops at once, next grant starts at CPU0.
        do_reset();
        dREN = 2'b01; ramstate = S_ACC;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        dREN = 2'b10; ramstate = S_BUSY;
        @(posedge CLK); #1;
        #3;
        check("mid_pre_ren", {ramREN, ramaddr}, {1'b1, 32'h84});
        RST = 1'b1;
        #1;
        check("mid_rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 66'd0);
        check("mid_rst_dwait", dwait, 2'b10);
        @(posedge CLK); #1;
        RST = 1'b0;
`ifdef MEM_ARB_PERF_EN
        check("mid_rst_counts", grant_count, 64'd0);
`endif
        dREN = 2'b11; ramstate = S_ACC;
        @(posedge CLK); #1;
        #3;
        check("mid_post_grant", {ramREN, ramaddr}, {1'b1, 32'h80});
        @(posedge CLK); #1;

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < CPUS; c++) begin
                iREN[c]   = ($urandom_range(0, 2) == 0);
                dREN[c]   = ($urandom_range(0, 2) == 0);
                dWEN[c]   = ($urandom_range(0, 3) == 0);
                iaddr[c]  = $urandom;
                daddr[c]  = $urandom;
                dstore[c] = $urandom;
            end
            ramstate = 2'($urandom_range(0, 3));
            ramload  = $urandom;
            #4;
            model_step();
            @(posedge CLK); #1;
        end
`ifdef MEM_ARB_PERF_EN
        #1;
        check("rnd_count0", grant_count[0], m_cnt[0]);
        check("rnd_count1", grant_count[1], m_cnt[1]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter CPUS, default 2: number of CPU ports (1 to 8).
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter WORD_W, default 32: data word width.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 iREN  in  CPUS  per-CPU instruction read request.
REQ-007 dREN, dWEN  in  CPUS each  per-CPU data read and data write requests.
REQ-008 iaddr, daddr  in  CPUS x ADDR_W  per-CPU instruction and data addresses.
REQ-009 dstore  in  CPUS x WORD_W  per-CPU write data.
REQ-010 iwait, dwait  out  CPUS each  per-CPU stall; low means the access completes this cycle.
REQ-011 iload, dload  out  CPUS x WORD_W  per-CPU read data; every lane is driven from ramload.
REQ-012 ramREN, ramWEN  out  1 each  RAM read and write strobes.
REQ-013 ramaddr  out  ADDR_W  RAM address; ramstore  out  WORD_W  RAM write data.
REQ-014 ramload  in  WORD_W  RAM read data; ramstate  in  2  RAM status, one of FREE, BUSY, ACCESS or ERROR.

Function
REQ-015 The FSM SHALL have two states: IDLE and XFER.
REQ-016 In IDLE, requester selection SHALL proceed as follows:
- Search CPUs in round-robin order, starting at pointer rr.
- Select the first CPU with any request.
- Register the grant (owner, kind) and move to XFER.
- With no request, stay in IDLE.
REQ-017 Within one CPU, the granted kind SHALL follow the priority dWEN > dREN > iREN; if dWEN and dREN are both high, the access is a write.
REQ-018 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL all be 0.
REQ-019 In XFER, the RAM outputs SHALL be driven from the owner's live inputs:
- kind WRITE: ramWEN=1, ramaddr=daddr, ramstore=dstore.
- kind DREAD: ramREN=1, ramaddr=daddr.
- kind IREAD: ramREN=1, ramaddr=iaddr.
REQ-020 Each wait output SHALL equal its request AND NOT done, where done is high only for the granted owner and kind, in XFER, with ramstate==ACCESS.
REQ-021 On done, the FSM SHALL return to IDLE and set rr to (owner+1) mod CPUS.
- This gives one bubble cycle between grants.
- Minimum latency, request to low wait: 2 cycles.
REQ-022 If ramstate==ERROR in XFER, the FSM SHALL return to IDLE with rr unchanged; wait stays high and the same requester re-arbitrates first.
REQ-023 If the owner drops the granted request in XFER, the FSM SHALL abort to IDLE with no completion, rr = owner+1, and no RAM strobe in the abort cycle.
REQ-024 New requests, and requests from other CPUs, arriving during XFER SHALL NOT affect the current grant.
REQ-025 The rr pointer SHALL wrap from CPUS-1 to 0; with CPUS=1, rr is constant 0.

Reset
REQ-026 RST SHALL force the following, immediately and asynchronously:
- state=IDLE, rr=0, grant registers cleared.
- ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Every wait output equals its request.
REQ-027 A reset asserted during XFER SHALL drop the RAM strobes in the same cycle; no completion is reported.

Configuration
REQ-028 Macro MEM_ARB_PERF_EN: when defined, the block SHALL include:
- Output grant_count, CPUS x 32 bits.
- Entry c increments on each done for CPU c and saturates at all-ones.
- Cleared by RST.
REQ-029 Without MEM_ARB_PERF_EN, the port and the counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-030 ramstate_t and word_t SHALL come from cpu_types_pkg.
REQ-031 A new package mem_arb_pkg SHALL hold arb_state_t (IDLE, XFER) and grant_kind_t (IREAD, DREAD, WRITE).
REQ-032 The round-robin pick SHALL be a combinational sub-module rr_picker:
- Inputs: request vector, pointer.
- Outputs: index and valid.

Verification
REQ-033 CPUS=2, only iREN[0]=1, iaddr[0]=0x40, RAM returns ACCESS in cycle 2 with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 in cycle 1; iwait[0]=0 and iload[0]=0xDEADBEEF in cycle 2.
REQ-034 CPU0 asserts dWEN, dREN and iREN together, daddr=0x80, dstore=0x5 -> a single write with ramWEN=1, ramstore=0x5; dwait[0]=1 persists after completion because dREN is still pending.
REQ-035 Both CPUs continuously request dREN -> grants alternate 0,1,0,1, starting at 0 after reset.
REQ-036 ramstate=ERROR on CPU1's grant while CPU0 is also requesting -> CPU1 is re-granted next, ahead of CPU0.
REQ-037 RST pulsed mid-XFER -> ramREN=0 asynchronously; after release, grant begins at CPU0; with MEM_ARB_PERF_EN, all counts read 0.
